// File: rtl/fixpt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fixpt_pkg
//  Brief    : Q1.20 fixed-point constants and saturation helper shared by the
//             Integrator and the differentiator.
//  Revision : 1.0  initial release
// ============================================================================
package fixpt_pkg;

    localparam int DATA_W = 22;
    localparam int FRAC_W = 20;

    localparam logic [DATA_W-1:0] SAT_MAX = 22'h1FFFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 22'h200000;

    typedef struct packed {
        logic              sat;
        logic [DATA_W-1:0] data;
    } sat_res_t;

    // One guard bit is enough: the two top bits disagree exactly on overflow.
    function automatic sat_res_t saturate(input logic signed [DATA_W:0] d);
        sat_res_t r;
        if (d[DATA_W] != d[DATA_W-1]) begin
            r.sat  = 1'b1;
            r.data = d[DATA_W] ? SAT_MIN : SAT_MAX;
        end else begin
            r.sat  = 1'b0;
            r.data = d[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/differentiator_if.sv
`default_nettype none
// ============================================================================
//  Module   : differentiator_if
//  Brief    : Sample stream in, saturated difference stream and flags out.
//  Revision : 1.0  initial release
// ============================================================================
interface differentiator_if #(
    parameter int DATA_W = fixpt_pkg::DATA_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              sat;
    logic              ovf;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, sat, ovf
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, sat, ovf
    );
endinterface
`default_nettype wire

// File: rtl/diff_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : diff_delay_line
//  Brief    : DELAY-entry circular history; dout_old is the sample M pushes ago.
//  Revision : 1.0  initial release
// ============================================================================
module diff_delay_line
    import fixpt_pkg::*;
#(
    parameter int DATA_W = fixpt_pkg::DATA_W,
    parameter int DELAY  = 1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              clear,
    input  wire logic              push,
    input  wire logic [DATA_W-1:0] din,
    output logic      [DATA_W-1:0] dout_old
);

    localparam int AW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [AW-1:0] c_LAST = AW'(DELAY - 1);

    logic [DATA_W-1:0] r_buf [DELAY];
    logic [AW-1:0]     r_wp;

    // Combinational read of the entry about to be overwritten yields the old value.
    assign dout_old = r_buf[r_wp];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < DELAY; i++) begin
                r_buf[i] <= '0;
            end
            r_wp <= '0;
        end else if (push) begin
            r_buf[r_wp] <= din;
            r_wp        <= (r_wp == c_LAST) ? '0 : r_wp + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/differentiator.sv
`default_nettype none
// ============================================================================
//  Module   : differentiator
//  Brief    : y[n] = x[n] - x[n-M] on Q1.20 samples, saturated, 2-cycle latency.
//  Revision : 1.0  initial release
// ============================================================================
module differentiator
    import fixpt_pkg::*;
#(
    parameter int DATA_W = fixpt_pkg::DATA_W,
    parameter int DELAY  = 1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        clear,
    differentiator_if.slave  bus
);

    logic [DATA_W-1:0]     w_old;
    logic signed [DATA_W:0] r_d;
    logic                  r_d_valid;
    logic                  r_out_valid;
    logic [DATA_W-1:0]     r_out_data;
    logic                  r_sat;
    logic                  r_ovf;
    sat_res_t              w_sat;

    diff_delay_line #(
        .DATA_W (DATA_W),
        .DELAY  (DELAY)
    ) u_delay_line (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .push     (bus.in_valid),
        .din      (bus.in_data),
        .dout_old (w_old)
    );

    assign w_sat = saturate(r_d);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_d_valid <= 1'b0;
            r_d       <= '0;
        end else begin
            r_d_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_d <= $signed({bus.in_data[DATA_W-1], bus.in_data})
                     - $signed({w_old[DATA_W-1], w_old});
            end
        end
    end

    // ovf rises together with the first saturated output it reports.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat       <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_out_valid <= r_d_valid;
            r_sat       <= r_d_valid & w_sat.sat;
            r_ovf       <= r_ovf | (r_d_valid & w_sat.sat);
            if (r_d_valid) begin
                r_out_data <= w_sat.data;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.sat       = r_sat;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_differentiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_differentiator
//  Brief    : Randomised and directed bench for differentiator, DELAY=1 and 4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_differentiator;
    import fixpt_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    differentiator_if #(.DATA_W(DATA_W)) if1 ();
    differentiator_if #(.DATA_W(DATA_W)) if4 ();

    assign if1.in_valid = in_valid;
    assign if1.in_data  = in_data;
    assign if4.in_valid = in_valid;
    assign if4.in_data  = in_data;

    differentiator #(.DATA_W(DATA_W), .DELAY(1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .bus(if1.slave));
    differentiator #(.DATA_W(DATA_W), .DELAY(4)) dut4 (
        .clk(clk), .reset(reset), .clear(clear), .bus(if4.slave));

    // Reference model: full history of valid samples since reset/clear.
    int                hist[$];
    int                c_m [2] = '{1, 4};
    logic              pend_v [2];
    logic [DATA_W-1:0] pend_d [2];
    logic              pend_s [2];
    logic              e_v [2];
    logic [DATA_W-1:0] e_d [2];
    logic              e_s [2];
    logic              e_o [2];

    // Round-trip: integrated samples fed in, originals expected back out.
    bit rt_on = 0;
    int rt_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int x, old, y;
        if (reset) begin
            hist.delete();
            for (int k = 0; k < 2; k++) begin
                pend_v[k] = 0; e_v[k] = 0; e_d[k] = '0; e_s[k] = 0; e_o[k] = 0;
            end
        end else if (clear) begin
            hist.delete();
            for (int k = 0; k < 2; k++) begin
                pend_v[k] = 0; e_v[k] = 0; e_s[k] = 0;
            end
        end else begin
            x = $signed(in_data);
            for (int k = 0; k < 2; k++) begin
                e_v[k] = pend_v[k];
                e_s[k] = pend_v[k] & pend_s[k];
                if (pend_v[k]) e_d[k] = pend_d[k];
                e_o[k] = e_o[k] | e_s[k];
                pend_v[k] = in_valid;
                if (in_valid) begin
                    old = (hist.size() >= c_m[k]) ? hist[hist.size() - c_m[k]] : 0;
                    y = x - old;
                    if (y > 2097151) begin
                        pend_d[k] = 22'h1FFFFF; pend_s[k] = 1;
                    end else if (y < -2097152) begin
                        pend_d[k] = 22'h200000; pend_s[k] = 1;
                    end else begin
                        pend_d[k] = y[DATA_W-1:0]; pend_s[k] = 0;
                    end
                end
            end
            if (in_valid) begin
                hist.push_back(x);
                if (hist.size() > 16) void'(hist.pop_front());
            end
        end
    endtask

    task automatic step(input logic v, input logic [DATA_W-1:0] x,
                        input logic clr, input logic rst);
        int want;
        in_valid = v; in_data = x; clear = clr; reset = rst;
        @(posedge clk);
        model_edge();
        #1;
        check("m1_valid", 32'(if1.out_valid), 32'(e_v[0]));
        check("m1_data",  32'(if1.out_data),  32'(e_d[0]));
        check("m1_sat",   32'(if1.sat),       32'(e_s[0]));
        check("m1_ovf",   32'(if1.ovf),       32'(e_o[0]));
        check("m4_valid", 32'(if4.out_valid), 32'(e_v[1]));
        check("m4_data",  32'(if4.out_data),  32'(e_d[1]));
        check("m4_sat",   32'(if4.sat),       32'(e_s[1]));
        check("m4_ovf",   32'(if4.ovf),       32'(e_o[1]));
        if (if1.out_valid) begin
            $display("y %f", $itor($signed(if1.out_data)) / 1048576.0);
            if (rt_on && rt_q.size() > 0) begin
                want = rt_q.pop_front();
                check("roundtrip", 32'(if1.out_data), 32'(want[DATA_W-1:0]));
            end
        end
    endtask

    initial begin
        int acc, xr;
        logic [DATA_W-1:0] xv;

        // Reset state
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        check("rst_valid", 32'(if1.out_valid), 32'd0);
        check("rst_data",  32'(if1.out_data),  32'd0);
        check("rst_ovf",   32'(if4.ovf),       32'd0);

        // Constant 1.0
        for (int i = 0; i < 6; i++) step(1, 22'h100000, 0, 0);
        check("const_zero", 32'(if1.out_data), 32'd0);

        // Ramp with bubbles
        step(0, '0, 1, 0);
        for (int i = 0; i < 16; i++) step(i[0] == 1'b0, 22'((i / 2) * 22'h000400), 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);

        // Saturation both directions, ovf stays sticky across clear
        step(0, '0, 1, 0);
        step(1, 22'h200000, 0, 0);
        step(1, 22'h1FFFFF, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        check("ovf_set", 32'(if1.ovf), 32'd1);
        step(0, '0, 1, 0);
        step(1, 22'h1FFFFF, 0, 0);
        step(1, 22'h200000, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 1, 0);
        check("ovf_kept", 32'(if1.ovf), 32'd1);
        step(0, '0, 0, 1);
        check("ovf_reset", 32'(if1.ovf), 32'd0);

        // Pointer wrap at DELAY=4
        for (int i = 1; i <= 8; i++) step(1, 22'(i * 22'h000100), 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        check("wrap_last", 32'(if4.out_data), 32'h400);

        // Clear with in_valid mid-stream
        step(0, '0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 22'h050000, 0, 0);
        step(1, 22'h050000, 1, 0);
        step(1, 22'h050000, 0, 0);
        step(0, '0, 0, 0);
        check("after_clear", 32'(if1.out_data), 32'h050000);

        // Integrate -> differentiate round trip at DELAY=1
        step(0, '0, 1, 0);
        rt_on = 1;
        acc = 0;
        for (int i = 0; i < 120; i++) begin
            xr = int'($urandom_range(0, 8192)) - 4096;
            acc += xr;
            rt_q.push_back(xr);
            step(1, 22'(acc), 0, 0);
            if ($urandom_range(0, 3) == 0) step(0, '0, 0, 0);
        end
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        check("rt_drained", 32'(rt_q.size()), 32'd0);
        rt_on = 0;

        // Random stream including extremes, clears and resets
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 5))
                0:       xv = 22'h1FFFFF;
                1:       xv = 22'h200000;
                default: xv = 22'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, xv,
                 $urandom_range(0, 63) == 0, $urandom_range(0, 199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
